// File: rtl/common_params.sv
// Shared boot/load constants: destination codes, word widths and the boot FSM state type.
package common_params;
  localparam logic [2:0] I_MEM        = 3'b100;
  localparam logic [2:0] D_MEM        = 3'b010;
  localparam logic [2:0] IMAGE_BUFFER = 3'b001;

  localparam int IB_DW_PB      = 384;
  localparam int IB_DW         = IB_DW_PB * 8;
  localparam int I_D_MEM_DW_PB = 4;
  localparam int ADDR_WIDTH_PB = $clog2(I_D_MEM_DW_PB);
  localparam int IB_IDX_W      = 9;

  localparam logic [7:0] BOOT_CMD_DONE = 8'hFF;

  typedef enum logic [2:0] {IDLE, A_LO, A_HI, C_LO, C_HI, DATA, CHK} boot_state_t;

  typedef struct packed {
    logic imem;
    logic dmem;
    logic ib;
  } boot_we_t;

  function automatic logic cmd_is_load(input logic [7:0] c);
    return (c[7:3] == 5'd0) &&
           (c[2:0] == I_MEM || c[2:0] == D_MEM || c[2:0] == IMAGE_BUFFER);
  endfunction
endpackage

// File: rtl/boot_loader_fsm_word_asm.sv
// Little-endian byte-lane assembler: byte index counter plus the wide wr_data register.
module boot_word_asm
  import common_params::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             byte_vld,
  input  logic [7:0]       byte_in,
  input  logic             is_ib,
  output logic [IB_DW-1:0] data,
  output logic             word_complete
);
  logic [IB_IDX_W-1:0] idx_q, idx_d, last_idx;
  logic [IB_DW-1:0]    data_q, data_d;

  // Memories only ever reach index 3, so one 9-bit counter serves both widths.
  assign last_idx      = is_ib ? IB_IDX_W'(IB_DW_PB - 1) : IB_IDX_W'(I_D_MEM_DW_PB - 1);
  assign word_complete = byte_vld && (idx_q == last_idx);
  assign data          = data_q;

  always_comb begin
    idx_d  = idx_q;
    data_d = data_q;
    if (clr) begin
      idx_d = '0;
    end else if (byte_vld) begin
      data_d[idx_q*8 +: 8] = byte_in;
      idx_d = word_complete ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      data_q <= '0;
    end else begin
      idx_q  <= idx_d;
      data_q <= data_d;
    end
  end
endmodule

// File: rtl/boot_loader_fsm.sv
// Boot frame parser: UART bytes -> word writes to imem/dmem/image buffer; holds CPU in reset.
// Optional trailing XOR checksum byte when BOOT_CHECKSUM_EN is defined.
module boot_loader_fsm
  import common_params::*;
#(
  parameter int         AW       = 16,
  parameter logic [7:0] CMD_DONE = BOOT_CMD_DONE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [7:0]       rx_byte,
  output logic [AW-1:0]    wr_addr,
  output logic [IB_DW-1:0] wr_data,
  output logic             we_imem,
  output logic             we_dmem,
  output logic             we_ib,
  output logic             cpu_rst,
  output logic             boot_done,
`ifdef BOOT_CHECKSUM_EN
  output logic             csum_err,
`endif
  output logic             frame_err
);
  boot_state_t state_q, state_d;
  logic [2:0]  dest_q, dest_d;
  logic [AW-1:0] addr_q, addr_d, cnt_q, cnt_d, cnt_full;
  logic [15:0] addr_tmp, cnt_tmp;
  boot_we_t    we_q, we_d;
  logic        cpu_rst_q, cpu_rst_d, boot_done_q, boot_done_d, frame_err_q, frame_err_d;
  logic        asm_vld, asm_clr, word_complete;
  boot_state_t after_data;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
  logic        csum_err_q, csum_err_d;
  assign after_data = CHK;
  assign csum_err   = csum_err_q;
`else
  assign after_data = IDLE;
`endif

  assign asm_vld = rx_valid && (state_q == DATA);
  assign asm_clr = (state_q != DATA);

  boot_word_asm u_asm (
    .clk           (clk),
    .rst           (rst),
    .clr           (asm_clr),
    .byte_vld      (asm_vld),
    .byte_in       (rx_byte),
    .is_ib         (dest_q == IMAGE_BUFFER),
    .data          (wr_data),
    .word_complete (word_complete)
  );

  assign cnt_full = AW'({rx_byte, 8'(cnt_q)});

  always_comb begin
    state_d     = state_q;
    dest_d      = dest_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    we_d        = '0;
    cpu_rst_d   = cpu_rst_q;
    boot_done_d = boot_done_q;
    frame_err_d = frame_err_q;
    addr_tmp    = 16'(addr_q);
    cnt_tmp     = 16'(cnt_q);
`ifdef BOOT_CHECKSUM_EN
    csum_d      = csum_q;
    csum_err_d  = csum_err_q;
    if (rx_valid && state_q != IDLE && state_q != CHK) csum_d = csum_q ^ rx_byte;
`endif
    // Post-strobe increment; never coincides with an address-byte load.
    if (we_q != '0) addr_d = addr_q + 1'b1;

    case (state_q)
      IDLE: if (rx_valid) begin
        if (rx_byte == CMD_DONE) begin
          boot_done_d = 1'b1;
          cpu_rst_d   = 1'b0;
        end else if (cmd_is_load(rx_byte)) begin
          dest_d    = rx_byte[2:0];
          cpu_rst_d = 1'b1;
          state_d   = A_LO;
`ifdef BOOT_CHECKSUM_EN
          csum_d    = rx_byte;
`endif
        end else begin
          frame_err_d = 1'b1;
        end
      end
      A_LO: if (rx_valid) begin
        addr_tmp[7:0] = rx_byte;
        addr_d        = AW'(addr_tmp);
        state_d       = A_HI;
      end
      A_HI: if (rx_valid) begin
        addr_tmp[15:8] = rx_byte;
        addr_d         = AW'(addr_tmp);
        state_d        = C_LO;
      end
      C_LO: if (rx_valid) begin
        cnt_tmp[7:0] = rx_byte;
        cnt_d        = AW'(cnt_tmp);
        state_d      = C_HI;
      end
      C_HI: if (rx_valid) begin
        cnt_d   = cnt_full;
        state_d = (cnt_full == '0) ? after_data : DATA;
      end
      DATA: if (word_complete) begin
        we_d.imem = (dest_q == I_MEM);
        we_d.dmem = (dest_q == D_MEM);
        we_d.ib   = (dest_q == IMAGE_BUFFER);
        cnt_d     = cnt_q - 1'b1;
        if (cnt_q == AW'(1)) state_d = after_data;
      end
`ifdef BOOT_CHECKSUM_EN
      CHK: if (rx_valid) begin
        if (rx_byte != csum_q) csum_err_d = 1'b1;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      dest_q      <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      we_q        <= '0;
      cpu_rst_q   <= 1'b1;
      boot_done_q <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      csum_q      <= '0;
      csum_err_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      dest_q      <= dest_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      cpu_rst_q   <= cpu_rst_d;
      boot_done_q <= boot_done_d;
      frame_err_q <= frame_err_d;
`ifdef BOOT_CHECKSUM_EN
      csum_q      <= csum_d;
      csum_err_q  <= csum_err_d;
`endif
    end
  end

  assign wr_addr   = addr_q;
  assign we_imem   = we_q.imem;
  assign we_dmem   = we_q.dmem;
  assign we_ib     = we_q.ib;
  assign cpu_rst   = cpu_rst_q;
  assign boot_done = boot_done_q;
  assign frame_err = frame_err_q;
endmodule

// File: tb/tb_boot_loader_fsm.sv
// Directed bench for boot_loader_fsm: byte driver with a write scoreboard checked by a strobe monitor.
module tb_boot_loader_fsm;
  localparam int DW = 3072;

  logic          clk = 1'b0, rst = 1'b1, rx_valid = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic [15:0]   wr_addr;
  logic [DW-1:0] wr_data;
  logic          we_imem, we_dmem, we_ib, cpu_rst, boot_done, frame_err;
`ifdef BOOT_CHECKSUM_EN
  logic          csum_err;
`endif

  boot_loader_fsm dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .we_imem(we_imem), .we_dmem(we_dmem), .we_ib(we_ib),
    .cpu_rst(cpu_rst), .boot_done(boot_done),
`ifdef BOOT_CHECKSUM_EN
    .csum_err(csum_err),
`endif
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    we;
    logic [15:0]   addr;
    logic [DW-1:0] data;
    bit            full;
    int            cyc;
  } exp_t;

  exp_t q[$];
  int ncmp = 0, nfail = 0, cyc = 0;

  logic [2:0]    m_we;
  logic [15:0]   m_addr;
  int            m_bpw, m_idx;
  logic [DW-1:0] m_word = '0;
  logic [7:0]    m_x;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if ({we_imem, we_dmem, we_ib} != 3'b000) begin
      if (q.size() == 0) begin
        chk("spurious_we", {61'd0, we_imem, we_dmem, we_ib}, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("we", {61'd0, we_imem, we_dmem, we_ib}, {61'd0, e.we});
        chk("strobe_cyc", 64'(cyc), 64'(e.cyc));
        chk("addr", {48'd0, wr_addr}, {48'd0, e.addr});
        if (e.full) begin
          ncmp++;
          assert (wr_data === e.data) else begin
            int k;
            k = 0;
            while (k < DW/8 - 1 && wr_data[k*8 +: 8] === e.data[k*8 +: 8]) k++;
            nfail++;
            $error("FAIL data_ib: byte %0d observed %0h expected %0h", k, wr_data[k*8 +: 8], e.data[k*8 +: 8]);
          end
        end else begin
          chk("data32", {32'd0, wr_data[31:0]}, {32'd0, e.data[31:0]});
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_byte  = b;
    m_x      = m_x ^ b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; rx_valid = 1'b0; end
  endtask

  task automatic start(input logic [7:0] cmd, input logic [15:0] addr, input logic [15:0] cnt);
    m_x = 8'h00;
    send(cmd); send(addr[7:0]); send(addr[15:8]); send(cnt[7:0]); send(cnt[15:8]);
    m_we   = cmd[2:0];
    m_addr = addr;
    m_bpw  = (cmd[2:0] == 3'b001) ? 384 : 4;
    m_idx  = 0;
  endtask

  task automatic data(input logic [7:0] b);
    exp_t e;
    send(b);
    m_word[m_idx*8 +: 8] = b;
    m_idx++;
    if (m_idx == m_bpw) begin
      e.we = m_we; e.addr = m_addr; e.data = m_word; e.full = (m_bpw == 384); e.cyc = cyc + 1;
      q.push_back(e);
      m_addr = m_addr + 16'd1;
      m_idx  = 0;
    end
  endtask

  task automatic chk_byte(input logic [7:0] corrupt);
`ifdef BOOT_CHECKSUM_EN
    logic [7:0] b;
    b = m_x ^ corrupt;
    send(b);
`endif
  endtask

  task automatic drain(input string tag);
    idle(3);
    chk(tag, 64'(q.size()), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t1 [8];
    t1 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    idle(3);
    @(negedge clk);
    chk("rst_addr", {48'd0, wr_addr}, 64'd0);
    chk("rst_data", {63'd0, |wr_data}, 64'd0);
    chk("rst_we", {61'd0, we_imem, we_dmem, we_ib}, 64'd0);
    chk("rst_cpu_rst", {63'd0, cpu_rst}, 64'd1);
    chk("rst_boot_done", {63'd0, boot_done}, 64'd0);
    chk("rst_frame_err", {63'd0, frame_err}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // D_MEM, two words back-to-back; word 2's first byte lands in word 1's strobe cycle
    start(8'h02, 16'h0010, 16'd2);
    foreach (t1[i]) data(t1[i]);
    idle(1);
    chk("dmem_cpu_rst", {63'd0, cpu_rst}, 64'd1);
    drain("dmem_drain");

    // I_MEM zero count then end-of-boot
    start(8'h04, 16'h0020, 16'd0);
    chk_byte(8'h00);
    send(8'hFF);
    idle(1);
    chk("done_boot_done", {63'd0, boot_done}, 64'd1);
    chk("done_cpu_rst", {63'd0, cpu_rst}, 64'd0);

    // Image buffer row, one 384-byte word; re-entry reasserts cpu_rst
    start(8'h01, 16'h0003, 16'd1);
    chk("reentry_cpu_rst", {63'd0, cpu_rst}, 64'd1);
    chk("reentry_boot_done", {63'd0, boot_done}, 64'd1);
    for (int i = 0; i < 384; i++) data(8'(i));
    chk_byte(8'h00);
    drain("ib_drain");
    chk("ib_top_byte", {56'd0, wr_data[3071:3064]}, 64'h7F);
    chk("ib_low_byte", {56'd0, wr_data[7:0]}, 64'h00);

    // Illegal command, then a valid frame that wraps the address
    send(8'h07);
    idle(1);
    chk("frame_err_set", {63'd0, frame_err}, 64'd1);
    start(8'h02, 16'hFFFF, 16'd2);
    data(8'hA1); data(8'hA2); data(8'hA3); data(8'hA4);
    data(8'hB1); data(8'hB2); data(8'hB3); data(8'hB4);
    chk_byte(8'h00);
    drain("wrap_drain");
    chk("frame_err_sticky", {63'd0, frame_err}, 64'd1);

    // Reset in the middle of a data word: partial word discarded, no strobe
    start(8'h02, 16'h0040, 16'd1);
    data(8'h01); data(8'h02);
    @(posedge clk); #1 rx_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    m_word = '0;
    @(negedge clk);
    chk("midrst_boot_done", {63'd0, boot_done}, 64'd0);
    chk("midrst_frame_err", {63'd0, frame_err}, 64'd0);
    chk("midrst_cpu_rst", {63'd0, cpu_rst}, 64'd1);
    chk("midrst_addr", {48'd0, wr_addr}, 64'd0);
    start(8'h02, 16'h0050, 16'd1);
    data(8'hC1); data(8'hC2); data(8'hC3); data(8'hC4);
    chk_byte(8'h00);
    drain("postrst_drain");

`ifdef BOOT_CHECKSUM_EN
    chk("csum_ok", {63'd0, csum_err}, 64'd0);
    start(8'h02, 16'h0060, 16'd1);
    data(8'hD1); data(8'hD2); data(8'hD3); data(8'hD4);
    chk_byte(8'h5A);
    idle(1);
    chk("csum_bad", {63'd0, csum_err}, 64'd1);
    drain("csum_drain");
    start(8'h04, 16'h0000, 16'd0);
    chk_byte(8'h00);
    idle(1);
    chk("csum_sticky", {63'd0, csum_err}, 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("csum_rst", {63'd0, csum_err}, 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
